// File: rtl/slc3_button_conditioner.sv
// SLC-3 console input conditioner: synchronises and debounces the active-low
// Run/Continue buttons (pulse + held outputs) and synchronises the switch bus.
module slc3_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic pulse,
  output logic held
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REL,
    PWAIT,
    HELD,
    RWAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s1;
  logic          s2;

  // Sync flops reset to 1 so a button held through reset
  // is seen as a fresh falling edge once reset releases.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= REL;
      cnt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= 1'b0;
      unique case (state)
        REL: begin
          if (!s2) begin
            state <= PWAIT;
            cnt   <= '0;
          end
        end
        PWAIT: begin
          if (s2) begin
            state <= REL;
          end else if (cnt == LAST) begin
            state <= HELD;
            pulse <= 1'b1;
            held  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (s2) begin
            state <= RWAIT;
            cnt   <= '0;
          end
        end
        RWAIT: begin
          if (!s2) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state <= REL;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= REL;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

module slc3_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic                Continue,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                Run_pulse,
  output logic                Continue_pulse,
  output logic                Run_held,
  output logic                Continue_held,
  output logic [SW_WIDTH-1:0] SW_sync
);

  logic [SW_WIDTH-1:0] sw_s1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1   <= '0;
      SW_sync <= '0;
    end else begin
      sw_s1   <= SW;
      SW_sync <= sw_s1;
    end
  end

  slc3_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run (
    .Clk  (Clk),
    .Reset(Reset),
    .raw  (Run),
    .pulse(Run_pulse),
    .held (Run_held)
  );

  slc3_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cont (
    .Clk  (Clk),
    .Reset(Reset),
    .raw  (Continue),
    .pulse(Continue_pulse),
    .held (Continue_held)
  );

endmodule
